// File: rtl/tft_uart_pkg.sv
// Shared constants, widths and FSM encoding for the TFT UART control path.
package tft_uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam int OP_W   = 4;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_OP  = 3'd1,
        ST_GET_DH  = 3'd2,
        ST_GET_DL  = 3'd3,
        ST_GET_CHK = 3'd4
    } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle of byte-stream, reply and command signals around uart_cmd_parser.
interface uart_cmd_parser_if;
    import tft_uart_pkg::*;

    // rx side: rx_valid is a one-cycle strobe with no back-pressure.
    // tx side: strict valid/ready; tx_valid and tx_data hold steady until a
    // cycle with tx_valid & tx_ready, which is the single transfer cycle.
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_dat_update;
    logic [7:0]        err_cnt;
    state_t            dbg_state;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, cmd_opcode, cmd_data, cmd_dat_update, err_cnt, dbg_state
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, cmd_opcode, cmd_data, cmd_dat_update, err_cnt, dbg_state
    );

endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter; o_expire marks the cycle the count reaches TIMEOUT_CYC.
module uart_idle_timer #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear in the same cycle (a fresh byte) suppresses the expiry.
    assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/OP/DH/DL/CHK bytes into opcode/data commands and queues an ACK/NAK reply.
module uart_cmd_parser
    import tft_uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 17
) (
    input logic              clk,
    input logic              rst,
    uart_cmd_parser_if.slave io_bus
);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_op;
    logic [7:0]        r_dh;
    logic [7:0]        r_dl;
    logic [OP_W-1:0]   r_cmd_opcode;
    logic [DATA_W-1:0] r_cmd_data;
    logic              r_cmd_upd;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_err_cnt;

    logic w_expire;
    logic w_timeout;
    logic w_frame_done;
    logic w_frame_ok;
    logic w_slot_free;
    logic w_err_inc;

    uart_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (io_bus.rx_valid || (r_state == ST_IDLE)),
        .i_enable (r_state != ST_IDLE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:    if (io_bus.rx_valid && (io_bus.rx_data == SYNC_BYTE)) w_next = ST_GET_OP;
            ST_GET_OP:  if (io_bus.rx_valid) w_next = ST_GET_DH;
            ST_GET_DH:  if (io_bus.rx_valid) w_next = ST_GET_DL;
            ST_GET_DL:  if (io_bus.rx_valid) w_next = ST_GET_CHK;
            ST_GET_CHK: begin
                if (io_bus.rx_valid) begin
                    w_next       = ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
        // Expiry only occurs outside IDLE and never alongside a byte.
        if (w_expire) begin
            w_next    = ST_IDLE;
            w_timeout = 1'b1;
        end
    end

    assign w_frame_ok  = w_frame_done && (r_op[7:4] == 4'h0)
                         && (io_bus.rx_data == (r_op ^ r_dh ^ r_dl));
    assign w_slot_free = !r_tx_valid || io_bus.tx_ready;
    // One error per failed frame, even if it is both NAKed and its reply dropped.
    assign w_err_inc   = w_timeout || (w_frame_done && (!w_frame_ok || !w_slot_free));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
            r_dh <= '0;
            r_dl <= '0;
        end else if (io_bus.rx_valid) begin
            case (r_state)
                ST_GET_OP: r_op <= io_bus.rx_data;
                ST_GET_DH: r_dh <= io_bus.rx_data;
                ST_GET_DL: r_dl <= io_bus.rx_data;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_opcode <= '0;
            r_cmd_data   <= '0;
            r_cmd_upd    <= 1'b0;
        end else begin
            r_cmd_upd <= w_frame_ok;
            if (w_frame_ok) begin
                r_cmd_opcode <= r_op[OP_W-1:0];
                r_cmd_data   <= {r_dh, r_dl};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (r_tx_valid && io_bus.tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (w_frame_done && w_slot_free) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_frame_ok ? ACK_BYTE : NAK_BYTE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign io_bus.tx_data        = r_tx_data;
    assign io_bus.tx_valid       = r_tx_valid;
    assign io_bus.cmd_opcode     = r_cmd_opcode;
    assign io_bus.cmd_data       = r_cmd_data;
    assign io_bus.cmd_dat_update = r_cmd_upd;
    assign io_bus.err_cnt        = r_err_cnt;
    assign io_bus.dbg_state      = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: vector table, directed corner sequences, random stream vs reference model.
module tb_uart_cmd_parser;
    import tft_uart_pkg::*;

    localparam int T = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .TIMEOUT_CYC (T),
        .CNT_W       (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(dh);
        send_byte(dl);
        send_byte(chk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept_reply();
        bus.tx_ready = 1'b1;
        idle(1);
        bus.tx_ready = 1'b0;
        check("accept_txv", 32'(bus.tx_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // txd < 0 skips the reply byte check.
    task automatic expect_out(input string tag, input int upd, input int op, input int data,
                              input int txv, input int txd, input int err);
        check({tag, "_upd"},  32'(bus.cmd_dat_update), upd);
        check({tag, "_op"},   32'(bus.cmd_opcode), op);
        check({tag, "_data"}, 32'(bus.cmd_data), data);
        check({tag, "_txv"},  32'(bus.tx_valid), txv);
        if (txd >= 0) check({tag, "_txd"}, 32'(bus.tx_data), txd);
        check({tag, "_err"},  32'(bus.err_cnt), err);
    endtask

    // ---------------- reference model (frame-level) ----------------
    logic [7:0]  m_q[$];
    int          m_idle;
    logic        m_pend;
    logic        m_upd;
    logic [3:0]  m_op;
    logic [15:0] m_data;
    int          m_err;

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_idle = 0;
        m_pend = 1'b0;
        m_upd  = 1'b0;
        m_op   = 4'h0;
        m_data = 16'h0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic rxv, input logic [7:0] rxd, input logic txr);
        logic ok;
        m_upd = 1'b0;
        if (m_pend && txr) m_pend = 1'b0;
        if (rxv) begin
            m_idle = 0;
            if (m_q.size() > 0 || rxd == 8'hA5) m_q.push_back(rxd);
            if (m_q.size() == 5) begin
                ok = (m_q[1][7:4] == 4'h0) && (m_q[4] == (m_q[1] ^ m_q[2] ^ m_q[3]));
                if (ok) begin
                    m_upd  = 1'b1;
                    m_op   = m_q[1][3:0];
                    m_data = {m_q[2], m_q[3]};
                end
                if (!ok || m_pend) begin
                    if (m_err < 255) m_err++;
                end
                if (!m_pend) begin
                    m_pend = 1'b1;
                    exp_q.push_back(ok ? 8'h06 : 8'h15);
                end
                m_q.delete();
            end
        end else if (m_q.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_q.delete();
                m_idle = 0;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    // ---------------- random stream generator ----------------
    // Values >= 256 encode an idle gap of (value - 256) cycles.
    int stream[$];
    int gap_left;

    task automatic refill();
        int r;
        int n;
        logic [7:0] op;
        logic [7:0] dh;
        logic [7:0] dl;
        r  = $urandom_range(0, 9);
        op = {4'h0, 4'($urandom_range(0, 15))};
        dh = 8'($urandom);
        dl = 8'($urandom);
        case (r)
            5: begin
                stream.push_back('hA5); stream.push_back(int'(op));
                stream.push_back(int'(dh)); stream.push_back(int'(dl));
                stream.push_back(int'(op ^ dh ^ dl ^ 8'($urandom_range(1, 255))));
            end
            6: begin
                op[7:4] = 4'($urandom_range(1, 15));
                stream.push_back('hA5); stream.push_back(int'(op));
                stream.push_back(int'(dh)); stream.push_back(int'(dl));
                stream.push_back(int'(op ^ dh ^ dl));
            end
            7: begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) stream.push_back($urandom_range(0, 255));
            end
            8: begin
                stream.push_back('hA5); stream.push_back(int'(op));
                if ($urandom_range(0, 1) == 1) stream.push_back(int'(dh));
                stream.push_back(256 + $urandom_range(T - 3, T + 3));
            end
            default: begin
                stream.push_back('hA5); stream.push_back(int'(op));
                stream.push_back(int'(dh)); stream.push_back(int'(dl));
                stream.push_back(int'(op ^ dh ^ dl));
                if (r == 9) stream.push_back(256 + $urandom_range(0, 5));
            end
        endcase
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [39:0] b;
        int          upd;
        int          op;
        int          data;
        int          tx;
        int          err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       rxv;
        logic [7:0] rxd;
        logic       txr;
        int         n_hs;

        vecs[0] = '{40'hA5_03_12_34_25, 1, 'h3, 'h1234, 'h06, 0};
        vecs[1] = '{40'hA5_03_12_34_00, 0, 'h3, 'h1234, 'h15, 1};
        vecs[2] = '{40'hA5_01_00_0A_0B, 1, 'h1, 'h000A, 'h06, 1};
        vecs[3] = '{40'hA5_13_00_00_13, 0, 'h1, 'h000A, 'h15, 2};
        vecs[4] = '{40'hA5_0F_FF_FF_0F, 1, 'hF, 'hFFFF, 'h06, 2};
        vecs[5] = '{40'hA5_00_A5_A5_00, 1, 'h0, 'hA5A5, 'h06, 2};

        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        idle(3);
        check("rst_state", 32'(bus.dbg_state == ST_IDLE), 1);
        expect_out("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(1);

        // Table: each frame, reply held while tx_ready low, then accepted.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 5; k++) send_byte(vecs[i].b[39 - 8 * k -: 8]);
            expect_out($sformatf("vec%0d", i), vecs[i].upd, vecs[i].op, vecs[i].data,
                       1, vecs[i].tx, vecs[i].err);
            idle(1);
            expect_out($sformatf("vec%0d_hold", i), 0, vecs[i].op, vecs[i].data,
                       1, vecs[i].tx, vecs[i].err);
            accept_reply();
        end

        // Garbage bytes outside a frame are dropped without error.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("garbage_err", 32'(bus.err_cnt), 2);
        check("garbage_state", 32'(bus.dbg_state == ST_IDLE), 1);
        send_frame(8'h01, 8'h00, 8'h0A, 8'h0B);
        expect_out("after_garbage", 1, 'h1, 'h000A, 1, 'h06, 2);
        accept_reply();

        // Timeout boundary: still in a frame after T-1 idle cycles, IDLE after T.
        send_byte(8'hA5); send_byte(8'h03);
        idle(T - 1);
        check("tmo_not_yet", 32'(bus.dbg_state != ST_IDLE), 1);
        idle(1);
        check("tmo_state", 32'(bus.dbg_state == ST_IDLE), 1);
        expect_out("tmo", 0, 'h1, 'h000A, 0, -1, 3);
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        expect_out("tmo_next", 1, 'h3, 'h1234, 1, 'h06, 3);
        accept_reply();

        // Byte arriving in the expiry cycle wins over the timeout.
        send_byte(8'hA5); send_byte(8'h02);
        idle(T - 1);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h64);
        expect_out("expiry_race", 1, 'h2, 'hABCD, 1, 'h06, 3);
        accept_reply();

        // Two frames with tx_ready low: second reply dropped, both commands applied.
        send_frame(8'h01, 8'h00, 8'h0A, 8'h0B);
        expect_out("b2b_1", 1, 'h1, 'h000A, 1, 'h06, 3);
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h64);
        expect_out("b2b_2", 1, 'h2, 'hABCD, 1, 'h06, 4);
        bus.tx_ready = 1'b1;
        n_hs = 0;
        repeat (10) begin
            if (bus.tx_valid) n_hs++;
            idle(1);
        end
        bus.tx_ready = 1'b0;
        check("b2b_replies", 32'(n_hs), 1);

        // Reply completes in the cycle the old one is accepted: loaded, not dropped.
        send_frame(8'h03, 8'h12, 8'h34, 8'h25);
        expect_out("swap_1", 1, 'h3, 'h1234, 1, 'h06, 4);
        send_byte(8'hA5); send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
        bus.tx_ready = 1'b1;
        send_byte(8'h13);
        expect_out("swap_2", 0, 'h3, 'h1234, 1, 'h15, 5);
        idle(1);
        bus.tx_ready = 1'b0;
        check("swap_drain", 32'(bus.tx_valid), 0);

        // Asynchronous reset mid-frame aborts it; leftover bytes are garbage.
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
        rst = 1'b1;
        #2;
        check("mid_rst_state", 32'(bus.dbg_state == ST_IDLE), 1);
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h34); send_byte(8'h25);
        expect_out("post_rst_tail", 0, 0, 0, 0, -1, 0);
        send_frame(8'h01, 8'h00, 8'h0A, 8'h0B);
        expect_out("post_rst", 1, 'h1, 'h000A, 1, 'h06, 0);
        accept_reply();

        // Random stream against the frame-level model.
        do_reset();
        model_reset();
        stream.delete();
        gap_left = 0;
        for (int c = 0; c < 4000; c++) begin
            rxd = 8'h00;
            if (gap_left > 0) begin
                rxv = 1'b0;
                gap_left--;
            end else begin
                if (stream.size() == 0) refill();
                if (stream[0] >= 256) begin
                    gap_left = stream.pop_front() - 256;
                    rxv = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    rxv = 1'b1;
                    rxd = 8'(stream.pop_front());
                end else begin
                    rxv = 1'b0;
                end
            end
            txr = ($urandom_range(0, 2) == 0);
            bus.rx_valid = rxv;
            bus.rx_data  = rxd;
            bus.tx_ready = txr;
            if (bus.tx_valid && txr) begin
                check("rnd_tx_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("rnd_tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            model_step(rxv, rxd, txr);
            @(posedge clk);
            #1;
            check("rnd_txv",  32'(bus.tx_valid), 32'(m_pend));
            if (m_pend && exp_q.size() > 0) check("rnd_txd", 32'(bus.tx_data), 32'(exp_q[0]));
            check("rnd_upd",  32'(bus.cmd_dat_update), 32'(m_upd));
            check("rnd_op",   32'(bus.cmd_opcode), 32'(m_op));
            check("rnd_data", 32'(bus.cmd_data), 32'(m_data));
            check("rnd_err",  32'(bus.err_cnt), 32'(m_err));
        end
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;

        // Error counter saturation.
        do_reset();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 254; i++) send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        check("sat_254", 32'(bus.err_cnt), 'hFE);
        send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        check("sat_255", 32'(bus.err_cnt), 'hFF);
        send_frame(8'h03, 8'h12, 8'h34, 8'h00);
        check("sat_hold", 32'(bus.err_cnt), 'hFF);
        bus.tx_ready = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frames the raw byte stream from the UART receiver into validated 4-bit opcode / 16-bit data commands for `user_ctrl`. It returns an ACK/NAK byte to the UART transmitter for every complete frame. It sits between the UART byte receiver/transmitter and `user_ctrl`, inside the `tft_uart_ctrl` path, on the 100 MHz system clock.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 100000: inter-byte timeout in `clk` cycles (1 ms at 100 MHz).
- `CNT_W`, default 17: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- `clk`, in, 1: system clock (100 MHz). This is the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe, `rx_data` valid.
- `tx_data`, out, 8: reply byte to the UART transmitter.
- `tx_valid`, out, 1: reply pending; held until accepted.
- `tx_ready`, in, 1: transmitter accepts `tx_data` when `tx_valid & tx_ready`.
- `cmd_opcode`, out, 4: last valid opcode; holds its value between updates.
- `cmd_data`, out, 16: last valid data word; holds its value between updates.
- `cmd_dat_update`, out, 1: one-cycle pulse; new `cmd_opcode`/`cmd_data` are valid in the same cycle.
- `err_cnt`, out, 8: saturating count of NAKed, timed-out and dropped-reply frames.

## Operation
- Frame is 5 bytes: SYNC (0xA5), OP, DH, DL, CHK.
- OP[7:4] must be 0. CHK must equal OP ^ DH ^ DL.
- FSM states: IDLE, GET_OP, GET_DH, GET_DL, GET_CHK. A byte is consumed only on `rx_valid`.
  - IDLE: 0xA5 moves to GET_OP. Any other byte is discarded silently, with no error.
  - GET_OP → GET_DH → GET_DL → GET_CHK: each state latches its byte into a shadow register.
  - GET_CHK: the FSM always returns to IDLE.
    - Checksum OK and OP[7:4]==0: copy the shadows to `cmd_opcode`/`cmd_data`, pulse `cmd_dat_update`, queue ACK (0x06).
    - Otherwise: outputs unchanged, queue NAK (0x15), increment `err_cnt`.
- No resync inside a frame. 0xA5 in GET_OP..GET_CHK is treated as ordinary data.
- Timeout:
  - The counter clears on every `rx_valid` and in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYC in any non-IDLE state returns the FSM to IDLE, sends no reply, and increments `err_cnt`.
  - If `rx_valid` arrives in the same cycle as expiry, the byte wins and the timeout is ignored.
- Reply slot is one entry deep.
  - If a frame completes while `tx_valid` is still high, the new reply is dropped and `err_cnt` increments.
  - The command update still occurs if that frame was valid.
- `err_cnt` saturates at 0xFF.

## Timing
- Reset values: FSM in IDLE; `cmd_opcode`=0, `cmd_data`=0, `cmd_dat_update`=0, `tx_valid`=0, `tx_data`=0, `err_cnt`=0; timeout counter 0.
- Reset asserted mid-frame aborts the frame. No update and no reply are produced.
- Latency: `cmd_dat_update` and `tx_valid` rise on the clock edge after the cycle in which CHK has `rx_valid` high (1-cycle latency). The two rise together.
- `tx_valid` stays high and `tx_data` stays stable until the cycle with `tx_ready` high. `tx_valid` drops on the following edge.
- If a reply completes in the same cycle that `tx_ready` accepts the old one, the new reply is loaded (not dropped).
- Back-to-back `rx_valid` on consecutive cycles is supported. No throughput limit.
- Timeout fires exactly TIMEOUT_CYC cycles after the last accepted byte. FSM is in IDLE on the next edge.

## Structure
- Shared package `tft_uart_pkg`:
  - Constants SYNC_BYTE=0xA5, ACK_BYTE=0x06, NAK_BYTE=0x15.
  - FSM state encoding.
  - Opcode width (4) and data width (16), reused by `user_ctrl`.
- One sub-module, `uart_idle_timer`: a counter with `clear`, `enable` and an expiry pulse, parameterised by TIMEOUT_CYC/CNT_W.
- FSM, shadow registers, reply slot and error counter live in `uart_cmd_parser`.

## Test plan
- Valid frame A5 03 12 34 25 → one `cmd_dat_update` pulse, `cmd_opcode`=3, `cmd_data`=0x1234; `tx_data`=0x06 held until `tx_ready`; `err_cnt`=0.
- Bad checksum A5 03 12 34 00 → no update, outputs keep previous values, `tx_data`=0x15, `err_cnt`=1.
- Garbage 00 FF 5A, then valid frame A5 01 00 0A 0B → only the valid frame updates (`cmd_opcode`=1, `cmd_data`=0x000A); no errors counted for the garbage.
- A5 03, then idle for TIMEOUT_CYC cycles (test uses TIMEOUT_CYC=50), then full valid frame → first frame aborted with no reply and `err_cnt`=1; second frame ACKed.
- `tx_ready` held 0; send two valid frames back-to-back → both update commands, one ACK pending, `err_cnt`=1. Releasing `tx_ready` yields exactly one 0x06.
- Assert `rst` after A5 03 12 → all outputs return to reset values, no pulse, no reply. Next valid frame works normally.
